// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte-lane writes, registered reads and a sticky error code.
// Define DMEM_WAIT_STATES_EN to insert WAIT_STATES extra cycles per access via an IDLE/WAIT FSM.
module data_mem_responder #(
  parameter int unsigned                 DATA_WIDTH      = 32,
  parameter int unsigned                 DATA_ADDR_WIDTH = 32,
  parameter int unsigned                 DEPTH_WORDS     = 256,
  parameter logic [DATA_ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
  parameter int unsigned                 WAIT_STATES     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dMemRE,
  input  logic                       dMemWE,
  input  logic [3:0]                 dMemByteEn,
  input  logic [DATA_ADDR_WIDTH-1:0] dMemAddr,
  input  logic [DATA_WIDTH-1:0]      memWData,
  output logic [DATA_WIDTH-1:0]      memRData,
  output logic                       memRValid,
  output logic                       memReady,
  input  logic                       clearErr,
  output logic [1:0]                 errCode
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [DATA_ADDR_WIDTH:0] WinBytes = (DATA_ADDR_WIDTH+1)'(DEPTH_WORDS) << 2;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // The access being completed this cycle (live bus or captured copy).
  logic                       do_complete;
  logic                       op_re;
  logic                       op_we;
  logic [3:0]                 op_be;
  logic [DATA_ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0]      op_wdata;

`ifdef DMEM_WAIT_STATES_EN
  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       capture;
  logic                       req;
  logic                       cap_re_q, cap_we_q;
  logic [3:0]                 cap_be_q;
  logic [DATA_ADDR_WIDTH-1:0] cap_addr_q;
  logic [DATA_WIDTH-1:0]      cap_wdata_q;

  assign req = dMemRE | dMemWE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      cap_re_q    <= dMemRE;
      cap_we_q    <= dMemWE;
      cap_be_q    <= dMemByteEn;
      cap_addr_q  <= dMemAddr;
      cap_wdata_q <= memWData;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && (WAIT_STATES != 0)) begin
          capture = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    memReady    = (state_q == StIdle);
    do_complete = 1'b0;
    op_re       = dMemRE;
    op_we       = dMemWE;
    op_be       = dMemByteEn;
    op_addr     = dMemAddr;
    op_wdata    = memWData;
    if (state_q == StIdle) begin
      do_complete = req && (WAIT_STATES == 0);
    end else begin
      do_complete = (cnt_q == 4'd1);
      op_re       = cap_re_q;
      op_we       = cap_we_q;
      op_be       = cap_be_q;
      op_addr     = cap_addr_q;
      op_wdata    = cap_wdata_q;
    end
  end
`else
  assign memReady    = 1'b1;
  assign do_complete = dMemRE | dMemWE;
  assign op_re       = dMemRE;
  assign op_we       = dMemWE;
  assign op_be       = dMemByteEn;
  assign op_addr     = dMemAddr;
  assign op_wdata    = memWData;
`endif

  logic [DATA_ADDR_WIDTH-1:0] off;
  logic                       in_range;
  logic [IdxW-1:0]            idx;
  logic                       collide;
  logic                       wr_en;
  logic                       rd_en;

  assign off      = op_addr - BASE_ADDR;
  assign in_range = (op_addr >= BASE_ADDR) && ({1'b0, off} < WinBytes);
  assign idx      = off[IdxW+1:2];
  assign collide  = op_re & op_we;
  // A collision still commits the write; reset abandons any pending commit.
  assign wr_en    = do_complete & op_we & in_range & ~rst;
  assign rd_en    = do_complete & op_re & ~op_we;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (op_be[i]) mem[idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memRData  <= '0;
      memRValid <= 1'b0;
      errCode   <= 2'b00;
    end else begin
      memRValid <= rd_en;
      if (rd_en) memRData <= in_range ? mem[idx] : '0;
      if (do_complete && collide)        errCode <= 2'b10;
      else if (do_complete && !in_range) errCode <= 2'b01;
      else if (clearErr)                 errCode <= 2'b00;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, wait-state sequences and random ops
// checked against a transaction-level memory model.
module tb_data_mem_responder;

  localparam logic [31:0] B     = 32'h0000_1000;
  localparam int unsigned Depth = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        dMemRE, dMemWE, clearErr;
  logic [3:0]  dMemByteEn;
  logic [31:0] dMemAddr, memWData, memRData;
  logic        memRValid, memReady;
  logic [1:0]  errCode;

  data_mem_responder #(
    .DATA_WIDTH      (32),
    .DATA_ADDR_WIDTH (32),
    .DEPTH_WORDS     (Depth),
    .BASE_ADDR       (B),
    .WAIT_STATES     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dMemRE     (dMemRE),
    .dMemWE     (dMemWE),
    .dMemByteEn (dMemByteEn),
    .dMemAddr   (dMemAddr),
    .memWData   (memWData),
    .memRData   (memRData),
    .memRValid  (memRValid),
    .memReady   (memReady),
    .clearErr   (clearErr),
    .errCode    (errCode)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Transaction-level reference state.
  logic [31:0] m_mem [Depth];
  logic [31:0] m_rdata = '0;
  logic        m_valid = 1'b0;
  logic [1:0]  m_err   = 2'b00;

  typedef struct {
    logic        re;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        clr;
    logic [31:0] e_rdata;
    logic        e_valid;
    logic [1:0]  e_err;
    string       name;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_op(input logic re, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic clr);
    longint unsigned a;
    bit              inr;
    int unsigned     w;
    a   = 64'(addr);
    inr = (a >= 64'(B)) && (a < 64'(B) + 64'(Depth) * 4);
    w   = inr ? int'((a - 64'(B)) / 4) : 0;
    m_valid = 1'b0;
    if (re || we) begin
      if (re && !we) begin
        m_valid = 1'b1;
        m_rdata = inr ? m_mem[w] : 32'h0;
      end
      if (we && inr) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) m_mem[w][8*i +: 8] = wdata[8*i +: 8];
      end
      if (re && we)   m_err = 2'b10;
      else if (!inr)  m_err = 2'b01;
      else if (clr)   m_err = 2'b00;
    end else if (clr) begin
      m_err = 2'b00;
    end
  endtask

  // Present a request, hold it until the responder is ready again, then update the model.
  task automatic do_op(input logic re, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic clr);
    int cyc;
    dMemRE = re; dMemWE = we; dMemByteEn = be; dMemAddr = addr; memWData = wdata;
    clearErr = clr;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!memReady && cyc < 40);
    if (!memReady) check("op_timeout", {31'b0, memReady}, 32'd1);
    dMemRE = 1'b0; dMemWE = 1'b0; clearErr = 1'b0;
    model_op(re, we, be, addr, wdata, clr);
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = '0;
    tbl[0]  = '{1'b0, 1'b1, 4'hF, B + 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 2'd0, "wr_full"};
    tbl[1]  = '{1'b1, 1'b0, 4'hF, B + 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 2'd0, "rd_full"};
    tbl[2]  = '{1'b0, 1'b1, 4'hF, B + 32'h20,  32'h11223344, 1'b0, 32'hDEADBEEF, 1'b0, 2'd0, "wr_init"};
    tbl[3]  = '{1'b0, 1'b1, 4'h1, B + 32'h20,  32'h000000AA, 1'b0, 32'hDEADBEEF, 1'b0, 2'd0, "wr_b0"};
    tbl[4]  = '{1'b0, 1'b1, 4'hC, B + 32'h20,  32'hBBBB0000, 1'b0, 32'hDEADBEEF, 1'b0, 2'd0, "wr_hi"};
    tbl[5]  = '{1'b1, 1'b0, 4'hF, B + 32'h20,  32'h0,        1'b0, 32'hBBBB33AA, 1'b1, 2'd0, "rd_lanes"};
    tbl[6]  = '{1'b1, 1'b0, 4'hF, B + 32'h400, 32'h0,        1'b0, 32'h0,        1'b1, 2'd1, "rd_oor"};
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 32'h0,       32'h0,        1'b1, 32'h0,        1'b0, 2'd0, "clr"};
    tbl[8]  = '{1'b0, 1'b1, 4'hF, B + 32'h400, 32'h77,       1'b1, 32'h0,        1'b0, 2'd1, "wr_oor_clr"};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 32'h0,       32'h0,        1'b1, 32'h0,        1'b0, 2'd0, "clr2"};
    tbl[10] = '{1'b1, 1'b1, 4'hF, B,           32'h5,        1'b0, 32'h0,        1'b0, 2'd2, "collide"};
    tbl[11] = '{1'b1, 1'b0, 4'hF, B,           32'h0,        1'b0, 32'h5,        1'b1, 2'd2, "rd_after_coll"};
    tbl[12] = '{1'b0, 1'b0, 4'h0, 32'h0,       32'h0,        1'b1, 32'h5,        1'b0, 2'd0, "clr3"};
    tbl[13] = '{1'b0, 1'b1, 4'hF, B + 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h5,        1'b0, 2'd0, "wr_last"};
    tbl[14] = '{1'b1, 1'b0, 4'hF, B + 32'h3FC, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1, 2'd0, "rd_last"};
    tbl[15] = '{1'b1, 1'b0, 4'hF, B - 32'h4,   32'h0,        1'b0, 32'h0,        1'b1, 2'd1, "rd_below"};
    tbl[16] = '{1'b0, 1'b1, 4'h0, B + 32'h20,  32'hFFFFFFFF, 1'b1, 32'h0,        1'b0, 2'd0, "wr_be0_clr"};
    tbl[17] = '{1'b1, 1'b0, 4'hF, B + 32'h23,  32'h0,        1'b0, 32'hBBBB33AA, 1'b1, 2'd0, "rd_unaligned"};
    tbl[18] = '{1'b1, 1'b1, 4'hF, B + 32'h400, 32'h1,        1'b1, 32'hBBBB33AA, 1'b0, 2'd2, "collide_oor"};

    rst = 1'b1; dMemRE = 1'b0; dMemWE = 1'b0; dMemByteEn = '0; dMemAddr = '0;
    memWData = '0; clearErr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_rdata", memRData, 32'h0);
    check("rst_valid", {31'b0, memRValid}, 32'd0);
    check("rst_err",   {30'b0, errCode}, 32'd0);
    check("rst_ready", {31'b0, memReady}, 32'd1);

    for (int k = 0; k < 19; k++) begin
      do_op(tbl[k].re, tbl[k].we, tbl[k].be, tbl[k].addr, tbl[k].wdata, tbl[k].clr);
      check({tbl[k].name, "_rdata"}, memRData, tbl[k].e_rdata);
      check({tbl[k].name, "_valid"}, {31'b0, memRValid}, {31'b0, tbl[k].e_valid});
      check({tbl[k].name, "_err"},   {30'b0, errCode}, {30'b0, tbl[k].e_err});
      check({tbl[k].name, "_ready"}, {31'b0, memReady}, 32'd1);
    end

    // Read-valid is a single-cycle pulse.
    do_op(1'b1, 1'b0, 4'hF, B + 32'h10, 32'h0, 1'b0);
    check("pulse_hi", {31'b0, memRValid}, 32'd1);
    @(posedge clk); #1;
    check("pulse_lo", {31'b0, memRValid}, 32'd0);

    for (int i = 0; i < int'(Depth); i++)
      do_op(1'b0, 1'b1, 4'hF, B + 32'(i) * 4, $urandom, 1'b0);

`ifdef DMEM_WAIT_STATES_EN
    dMemRE = 1'b1; dMemAddr = B + 32'h10; dMemByteEn = 4'hF;
    @(posedge clk); #1;
    check("ws_ready_t1", {31'b0, memReady}, 32'd0);
    check("ws_valid_t1", {31'b0, memRValid}, 32'd0);
    @(posedge clk); #1;
    check("ws_ready_t2", {31'b0, memReady}, 32'd0);
    check("ws_valid_t2", {31'b0, memRValid}, 32'd0);
    @(posedge clk); #1;
    check("ws_ready_t3", {31'b0, memReady}, 32'd1);
    check("ws_valid_t3", {31'b0, memRValid}, 32'd1);
    check("ws_rdata_t3", memRData, m_mem[4]);
    dMemRE = 1'b0;
    model_op(1'b1, 1'b0, 4'hF, B + 32'h10, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("ws_valid_t4", {31'b0, memRValid}, 32'd0);

    dMemWE = 1'b1; dMemAddr = B + 32'h40; memWData = ~m_mem[16];
    @(posedge clk); #1;
    check("ws_rst_busy", {31'b0, memReady}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dMemWE = 1'b0;
    check("ws_rst_ready", {31'b0, memReady}, 32'd1);
    check("ws_rst_valid", {31'b0, memRValid}, 32'd0);
    m_err = 2'b00; m_rdata = '0; m_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("ws_rst_noval", {31'b0, memRValid}, 32'd0);
    do_op(1'b1, 1'b0, 4'hF, B + 32'h40, 32'h0, 1'b0);
    check("ws_rst_word", memRData, m_mem[16]);
`endif

    for (int n = 0; n < 300; n++) begin
      logic        re, we, clr;
      logic [3:0]  be;
      logic [31:0] addr;
      int unsigned k, r;
      k = $urandom_range(0, 9);
      re = (k <= 3) || (k == 8);
      we = (k >= 4 && k <= 8);
      r = $urandom_range(0, 9);
      if (r < 8)       addr = B + 32'($urandom_range(0, Depth - 1)) * 4 + 32'($urandom_range(0, 3));
      else if (r == 8) addr = B + Depth * 4 + 32'($urandom_range(0, 1023)) * 4;
      else             addr = B - 32'($urandom_range(1, 64)) * 4;
      be  = 4'($urandom);
      clr = ($urandom_range(0, 4) == 0);
      do_op(re, we, be, addr, $urandom, clr);
      check("rnd_rdata", memRData, m_rdata);
      check("rnd_valid", {31'b0, memRValid}, {31'b0, m_valid});
      check("rnd_err",   {30'b0, errCode}, {30'b0, m_err});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
